// File: rtl/clk_ratio_detector.sv
// Measures period and high time of a slow periodic sig_in in clk_in cycles, with lock and overflow flags.
// Define CLK_RATIO_SYNC_EN to pass an asynchronous sig_in through a 2-flop synchronizer first.
module clk_ratio_detector #(
   parameter int CNT_W    = 16,
   parameter int LOCK_CNT = 3
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             is_odd,
   output logic             locked,
   output logic             ovf
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam logic [3:0]       LOCK_V = 4'(LOCK_CNT);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic s_in;
`ifdef CLK_RATIO_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge clk_in) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], sig_in};
   end
   assign s_in = sync_q[1];
`else
   assign s_in = sig_in;
`endif

   logic             s_q, sd_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d, h_lat_q, h_lat_d;
   logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
   logic             mv_q, mv_d, odd_q, odd_d, locked_q, locked_d, ovf_q, ovf_d;
   logic [3:0]       match_q, match_d;
   logic             rise, fall, sat;

   assign rise = s_q & ~sd_q;
   assign fall = ~s_q & sd_q;
   assign sat  = (cnt_p_q == '1);

   always_comb begin
      state_d  = state_q;
      cnt_p_d  = cnt_p_q;
      cnt_h_d  = cnt_h_q;
      h_lat_d  = h_lat_q;
      period_d = period_q;
      high_d   = high_q;
      odd_d    = odd_q;
      mv_d     = 1'b0;
      match_d  = match_q;
      locked_d = locked_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            cnt_p_d = '0;
            cnt_h_d = '0;
            if (rise) begin
               state_d = HIGH;
               cnt_p_d = ONE;
               cnt_h_d = ONE;
            end
         end
         HIGH, LOW: begin
            // A rise landing on the saturation cycle still yields a valid period.
            if (rise && state_q == LOW) begin
               period_d = cnt_p_q;
               high_d   = h_lat_q;
               odd_d    = cnt_p_q[0];
               mv_d     = 1'b1;
               if ({cnt_p_q, h_lat_q} == {period_q, high_q})
                  match_d = (match_q >= LOCK_V) ? LOCK_V : match_q + 4'd1;
               else
                  match_d = 4'd0;
               locked_d = (match_d >= LOCK_V);
               cnt_p_d  = ONE;
               cnt_h_d  = ONE;
               state_d  = HIGH;
            end else if (sat) begin
               ovf_d    = 1'b1;
               match_d  = 4'd0;
               locked_d = 1'b0;
               cnt_p_d  = '0;
               cnt_h_d  = '0;
               state_d  = IDLE;
            end else begin
               cnt_p_d = cnt_p_q + ONE;
               if (state_q == HIGH) begin
                  cnt_h_d = cnt_h_q + ONE;
                  if (fall) begin
                     h_lat_d = cnt_h_q;
                     state_d = LOW;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         s_q      <= 1'b0;
         sd_q     <= 1'b0;
         state_q  <= IDLE;
         cnt_p_q  <= '0;
         cnt_h_q  <= '0;
         h_lat_q  <= '0;
         period_q <= '0;
         high_q   <= '0;
         mv_q     <= 1'b0;
         odd_q    <= 1'b0;
         locked_q <= 1'b0;
         ovf_q    <= 1'b0;
         match_q  <= 4'd0;
      end else begin
         s_q      <= s_in;
         sd_q     <= s_q;
         state_q  <= state_d;
         cnt_p_q  <= cnt_p_d;
         cnt_h_q  <= cnt_h_d;
         h_lat_q  <= h_lat_d;
         period_q <= period_d;
         high_q   <= high_d;
         mv_q     <= mv_d;
         odd_q    <= odd_d;
         locked_q <= locked_d;
         ovf_q    <= ovf_d;
         match_q  <= match_d;
      end
   end

   assign period     = period_q;
   assign high_time  = high_q;
   assign meas_valid = mv_q;
   assign is_odd     = odd_q;
   assign locked     = locked_q;
   assign ovf        = ovf_q;
endmodule

// File: tb/tb_clk_ratio_detector.sv
// Bench for clk_ratio_detector: table vectors, hand-written corner sequences and
// randomized waveforms checked every cycle against a timestamp-based reference model.
module tb_clk_ratio_detector;
   localparam int CNT_W = 4;
   localparam int LOCK  = 3;
   localparam int MAX   = (1 << CNT_W) - 1;
`ifdef CLK_RATIO_SYNC_EN
   localparam int D = 4;
`else
   localparam int D = 2;
`endif
   localparam int TRAIL = D + 1;

   logic             clk_in = 1'b0;
   logic             rst    = 1'b1;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period, high_time;
   logic             meas_valid, is_odd, locked, ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   clk_ratio_detector #(.CNT_W(CNT_W), .LOCK_CNT(LOCK)) dut (
      .clk_in(clk_in), .rst(rst), .sig_in(sig_in),
      .period(period), .high_time(high_time), .meas_valid(meas_valid),
      .is_odd(is_odd), .locked(locked), .ovf(ovf)
   );

   // Reference model: remembers the edge index of the measurement start and of the
   // first fall after it; period/high time are differences of those timestamps.
   logic [D-1:0] dlv = '0;
   int  e_cnt = 0, start_e = -1, fall_e = -1, m_match = 0;
   int  exp_per = 0, exp_high = 0;
   bit  exp_mv = 0, exp_odd = 0, exp_lock = 0, exp_ovf = 0;

   always @(posedge clk_in) begin : model
      bit r, f;
      int p, h;
      r = dlv[D-2] & ~dlv[D-1];
      f = ~dlv[D-2] & dlv[D-1];
      if (rst) begin
         dlv = '0; start_e = -1; fall_e = -1; m_match = 0;
         exp_per = 0; exp_high = 0; exp_mv = 0; exp_odd = 0; exp_lock = 0; exp_ovf = 0;
      end else begin
         exp_mv = 0;
         if (r) begin
            if (start_e >= 0) begin
               p = e_cnt - start_e;
               h = fall_e - start_e;
               if (p == exp_per && h == exp_high) m_match = (m_match >= LOCK) ? LOCK : m_match + 1;
               else m_match = 0;
               exp_per = p; exp_high = h; exp_odd = p[0]; exp_mv = 1;
               exp_lock = (m_match >= LOCK);
            end
            start_e = e_cnt;
            fall_e  = -1;
         end else if (start_e >= 0 && e_cnt - start_e >= MAX) begin
            exp_ovf = 1; m_match = 0; exp_lock = 0; start_e = -1;
         end else if (f && start_e >= 0 && fall_e < 0) begin
            fall_e = e_cnt;
         end
         dlv = {dlv[D-2:0], sig_in};
      end
      e_cnt++;
   end

   typedef struct { int per; int high; bit odd; bit lck; } pulse_t;
   pulse_t plog[$];

   typedef struct { int hi; int lo; int n; int pulses; int per; int high; bit odd; bit lck; bit ov; } vec_t;
   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
      checks++;
      if ({period, high_time, meas_valid, is_odd, locked, ovf} !==
          {exp_per[CNT_W-1:0], exp_high[CNT_W-1:0], exp_mv, exp_odd, exp_lock, exp_ovf}) begin
         errors++;
         $display("FAIL model @%0t: got p=%0d h=%0d v=%b odd=%b lk=%b ovf=%b expected p=%0d h=%0d v=%b odd=%b lk=%b ovf=%b",
                  $time, period, high_time, meas_valid, is_odd, locked, ovf,
                  exp_per, exp_high, exp_mv, exp_odd, exp_lock, exp_ovf);
      end
      if (meas_valid === 1'b1) plog.push_back('{int'(period), int'(high_time), is_odd, locked});
   endtask

   task automatic drive(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         sig_in = 1'b1; repeat (hi) tick();
         sig_in = 1'b0; repeat (lo) tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; sig_in = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_state", {period, high_time, meas_valid, is_odd, locked, ovf}, '0);
      plog.delete();
   endtask

   initial begin
      tbl[0] = '{3, 2, 5, 5,  5, 3, 1, 1, 0};
      tbl[1] = '{4, 4, 4, 4,  8, 4, 0, 1, 0};
      tbl[2] = '{1, 1, 6, 6,  2, 1, 0, 1, 0};
      tbl[3] = '{7, 8, 3, 3, 15, 7, 1, 0, 0};
      tbl[4] = '{8, 8, 3, 0,  0, 0, 0, 0, 1};
      tbl[5] = '{2, 3, 2, 2,  5, 2, 1, 0, 0};

      @(posedge clk_in);
      for (int v = 0; v < 6; v++) begin
         do_reset();
         drive(tbl[v].hi, tbl[v].lo, tbl[v].n);
         sig_in = 1'b1; repeat (TRAIL) tick();
         chk($sformatf("v%0d_pulses", v), plog.size(), tbl[v].pulses);
         foreach (plog[i]) begin
            chk($sformatf("v%0d_per%0d", v, i), plog[i].per, tbl[v].per);
            chk($sformatf("v%0d_high%0d", v, i), plog[i].high, tbl[v].high);
            chk($sformatf("v%0d_odd%0d", v, i), plog[i].odd, tbl[v].odd);
         end
         chk($sformatf("v%0d_locked", v), locked, tbl[v].lck);
         chk($sformatf("v%0d_ovf", v), ovf, tbl[v].ov);
      end

      // Ratio change while locked: old-ratio pulse keeps lock, first new-ratio pulse drops it.
      do_reset();
      drive(4, 4, 5);
      drive(2, 2, 3);
      sig_in = 1'b1; repeat (TRAIL) tick();
      chk("chg_pulses", plog.size(), 8);
      if (plog.size() == 8) begin
         chk("chg_lock4", plog[3].lck, 1);
         chk("chg_per5", plog[4].per, 8);
         chk("chg_lock5", plog[4].lck, 1);
         chk("chg_per6", plog[5].per, 4);
         chk("chg_high6", plog[5].high, 2);
         chk("chg_lock6", plog[5].lck, 0);
      end

      // Stuck high -> overflow, then resume.
      do_reset();
      drive(3, 2, 5);
      sig_in = 1'b1; repeat (20) tick();
      chk("ovf_pulses", plog.size(), 5);
      chk("ovf_set", ovf, 1);
      chk("ovf_unlock", locked, 0);
      sig_in = 1'b0; repeat (2) tick();
      drive(3, 2, 3);
      sig_in = 1'b1; repeat (TRAIL) tick();
      chk("resume_pulses", plog.size(), 8);
      if (plog.size() == 8) chk("resume_per", plog[5].per, 5);
      chk("resume_ovf", ovf, 1);

      // Reset mid-period while locked.
      do_reset();
      drive(3, 2, 5);
      sig_in = 1'b1; tick(); tick();
      chk("pre_rst_lock", locked, 1);
      rst = 1'b1; sig_in = 1'b0; tick();
      chk("post_rst_out", {period, high_time, meas_valid, is_odd, locked, ovf}, '0);
      rst = 1'b0; plog.delete();
      sig_in = 1'b1; repeat (3) tick();
      sig_in = 1'b0; repeat (6) tick();
      chk("rst_first_rise", plog.size(), 0);
      sig_in = 1'b1; repeat (TRAIL) tick();
      chk("rst_second_rise", plog.size(), 1);
      if (plog.size() == 1) begin
         chk("rst_per", plog[0].per, 9);
         chk("rst_high", plog[0].high, 3);
      end

      // Randomized waveforms, occasionally stuck long enough to overflow.
      do_reset();
      for (int k = 0; k < 60; k++) begin
         int hi, lo, rep;
         hi  = $urandom_range(1, 7);
         lo  = $urandom_range(1, 7);
         rep = $urandom_range(1, 5);
         if ($urandom_range(0, 9) == 0) hi = $urandom_range(14, 20);
         if ($urandom_range(0, 9) == 0) lo = $urandom_range(14, 20);
         drive(hi, lo, rep);
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b1; tick(); rst = 1'b0;
         end
      end
      repeat (20) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
